// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator: decodes one instruction per cycle and registers the result
// behind a two-entry (output + skid) elastic buffer. Define IMM_ZICSR_EN to decode SYSTEM/CSR immediates.
// XLEN must be 32 or 64.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_Z    = 3'd6;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t            state_reg, state_next;
  logic              in_ready_reg;
  logic              accept, out_xfer;
  logic              load_out, load_skid, move_skid;

  logic [XLEN-1:0]   dec_imm;
  logic [2:0]        dec_fmt;
  logic              dec_illegal;

  logic [XLEN-1:0]   out_imm_reg, skid_imm_reg;
  logic [2:0]        out_fmt_reg, skid_fmt_reg;
  logic              out_illegal_reg, skid_illegal_reg;
  logic [TAG_W-1:0]  out_tag_reg, skid_tag_reg;

  // Decode; the size casts of signed operands perform the sign extension to XLEN.
  always_comb begin
    dec_imm     = '0;
    dec_fmt     = FMT_NONE;
    dec_illegal = 1'b1;
    case (in_instr[6:0])
      OP_LOAD, OP_IMM, OP_JALR: begin
        dec_imm     = XLEN'($signed(in_instr[31:20]));
        dec_fmt     = FMT_I;
        dec_illegal = 1'b0;
      end
      OP_STORE: begin
        dec_imm     = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
        dec_fmt     = FMT_S;
        dec_illegal = 1'b0;
      end
      OP_BRANCH: begin
        dec_imm     = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                     in_instr[11:8], 1'b0}));
        dec_fmt     = FMT_B;
        dec_illegal = 1'b0;
      end
      OP_LUI, OP_AUIPC: begin
        dec_imm     = XLEN'($signed({in_instr[31:12], 12'b0}));
        dec_fmt     = FMT_U;
        dec_illegal = 1'b0;
      end
      OP_JAL: begin
        dec_imm     = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                     in_instr[30:21], 1'b0}));
        dec_fmt     = FMT_J;
        dec_illegal = 1'b0;
      end
      OP_REG: begin
        dec_illegal = 1'b0;
      end
      OP_IMM32: begin
        if (XLEN == 64) begin
          dec_imm     = XLEN'($signed(in_instr[31:20]));
          dec_fmt     = FMT_I;
          dec_illegal = 1'b0;
        end
      end
`ifdef IMM_ZICSR_EN
      OP_SYSTEM: begin
        if (in_instr[14:12] == 3'b100) begin
          dec_illegal = 1'b1;
        end else if (in_instr[14]) begin
          dec_imm     = XLEN'(in_instr[19:15]);
          dec_fmt     = FMT_Z;
          dec_illegal = 1'b0;
        end else if (in_instr[13:12] != 2'b00) begin
          dec_imm     = XLEN'(in_instr[31:20]);
          dec_fmt     = FMT_I;
          dec_illegal = 1'b0;
        end else begin
          dec_illegal = 1'b0;
        end
      end
`else
      OP_SYSTEM: begin
        dec_illegal = 1'b1;
      end
`endif
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  assign accept   = in_valid && in_ready_reg;
  assign out_xfer = out_valid && out_ready;

  always_comb begin
    state_next = state_reg;
    load_out   = 1'b0;
    load_skid  = 1'b0;
    move_skid  = 1'b0;
    case (state_reg)
      EMPTY: begin
        if (accept) begin
          load_out   = 1'b1;
          state_next = ONE;
        end
      end
      ONE: begin
        if (accept && out_xfer) begin
          load_out = 1'b1;
        end else if (accept) begin
          load_skid  = 1'b1;
          state_next = TWO;
        end else if (out_xfer) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        if (out_xfer) begin
          move_skid  = 1'b1;
          state_next = ONE;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

  // in_ready looks one state ahead so it never depends combinationally on out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= EMPTY;
      in_ready_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= (state_next != TWO);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_imm_reg     <= '0;
      out_fmt_reg     <= FMT_NONE;
      out_illegal_reg <= 1'b0;
      out_tag_reg     <= '0;
    end else if (load_out) begin
      out_imm_reg     <= dec_imm;
      out_fmt_reg     <= dec_fmt;
      out_illegal_reg <= dec_illegal;
      out_tag_reg     <= in_tag;
    end else if (move_skid) begin
      out_imm_reg     <= skid_imm_reg;
      out_fmt_reg     <= skid_fmt_reg;
      out_illegal_reg <= skid_illegal_reg;
      out_tag_reg     <= skid_tag_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_imm_reg     <= '0;
      skid_fmt_reg     <= FMT_NONE;
      skid_illegal_reg <= 1'b0;
      skid_tag_reg     <= '0;
    end else if (load_skid) begin
      skid_imm_reg     <= dec_imm;
      skid_fmt_reg     <= dec_fmt;
      skid_illegal_reg <= dec_illegal;
      skid_tag_reg     <= in_tag;
    end
  end

  assign in_ready    = in_ready_reg;
  assign out_valid   = (state_reg != EMPTY);
  assign out_imm     = out_imm_reg;
  assign out_fmt     = out_fmt_reg;
  assign out_illegal = out_illegal_reg;
  assign out_tag     = out_tag_reg;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: drives one XLEN=32 and one XLEN=64 instance with identical
// stimulus and scores each against its own queue of hand-derived expected results.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [4:0]  in_tag;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_imm32;
  logic [2:0]  out_fmt32;
  logic [4:0]  out_tag32;

  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;
  logic [2:0]  out_fmt64;
  logic [4:0]  out_tag64;

  imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_fmt(out_fmt32), .out_illegal(out_illegal32), .out_tag(out_tag32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_fmt(out_fmt64), .out_illegal(out_illegal64), .out_tag(out_tag64)
  );

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm32;
    logic [2:0]  fmt32;
    logic        ill32;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic        ill64;
  } vec_t;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [4:0]  tag;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  int   checks   = 0;
  int   failures = 0;
  int   cycles   = 0;

  function automatic vec_t mk(input logic [31:0] instr,
                              input logic [63:0] imm32, input logic [2:0] fmt32, input logic ill32,
                              input logic [63:0] imm64, input logic [2:0] fmt64, input logic ill64);
    vec_t v;
    v.instr = instr;
    v.imm32 = imm32; v.fmt32 = fmt32; v.ill32 = ill32;
    v.imm64 = imm64; v.fmt64 = fmt64; v.ill64 = ill64;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: score any output transfer, record any accept, then advance to the next negedge.
  task automatic tick(input vec_t v, output bit acc);
    exp_t e;
    bit   a32, a64;
    a32 = in_valid && in_ready32;
    a64 = in_valid && in_ready64;
    if (out_valid32 && out_ready) begin
      checks++;
      assert (q32.size() > 0) else begin
        failures++;
        $error("FAIL spurious32: observed tag=%0d expected no output", out_tag32);
      end
      if (q32.size() > 0) begin
        e = q32.pop_front();
        chk("imm32", {32'b0, out_imm32}, e.imm);
        chk("fmt32", {61'b0, out_fmt32}, {61'b0, e.fmt});
        chk("ill32", {63'b0, out_illegal32}, {63'b0, e.ill});
        chk("tag32", {59'b0, out_tag32}, {59'b0, e.tag});
      end
    end
    if (out_valid64 && out_ready) begin
      checks++;
      assert (q64.size() > 0) else begin
        failures++;
        $error("FAIL spurious64: observed tag=%0d expected no output", out_tag64);
      end
      if (q64.size() > 0) begin
        e = q64.pop_front();
        chk("imm64", out_imm64, e.imm);
        chk("fmt64", {61'b0, out_fmt64}, {61'b0, e.fmt});
        chk("ill64", {63'b0, out_illegal64}, {63'b0, e.ill});
        chk("tag64", {59'b0, out_tag64}, {59'b0, e.tag});
      end
    end
    if (a32) begin
      e.imm = v.imm32; e.fmt = v.fmt32; e.ill = v.ill32; e.tag = in_tag;
      q32.push_back(e);
    end
    if (a64) begin
      e.imm = v.imm64; e.fmt = v.fmt64; e.ill = v.ill64; e.tag = in_tag;
      q64.push_back(e);
    end
    acc = a32;
    @(posedge clk);
    @(negedge clk);
    cycles++;
  endtask

  // Offer an instruction until accepted (bounded); in_valid stays high for back-to-back sends.
  task automatic send(input vec_t v, input logic [4:0] tag);
    bit acc;
    int n;
    in_valid = 1'b1;
    in_instr = v.instr;
    in_tag   = tag;
    acc      = 1'b0;
    n        = 0;
    while (!acc && n < 50) begin
      tick(v, acc);
      n++;
    end
    checks++;
    assert (acc) else begin
      failures++;
      $error("FAIL send_timeout: observed no accept for instr=0x%08h expected accept", v.instr);
    end
  endtask

  task automatic idle(input int n);
    vec_t d;
    bit   acc;
    d = mk(32'h0, 64'h0, 3'd0, 1'b0, 64'h0, 3'd0, 1'b0);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick(d, acc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t va, vb, vc, vd, ve, vr, vw, vl, vu, vjn, vjr, vi1, vi2, vz1, vz2;
    vec_t vs;
    bit   acc;
    int   c0;

    va  = mk(32'hFFF00093, 64'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
    vb  = mk(32'hFE112E23, 64'hFFFFFFFC, 3'd2, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0);
    vc  = mk(32'hFE000CE3, 64'hFFFFFFF8, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFF8, 3'd3, 1'b0);
    vd  = mk(32'h800002B7, 64'h80000000, 3'd4, 1'b0, 64'hFFFFFFFF80000000, 3'd4, 1'b0);
    ve  = mk(32'h0000006F, 64'h0,        3'd5, 1'b0, 64'h0,                3'd5, 1'b0);
    vr  = mk(32'h002081B3, 64'h0,        3'd0, 1'b0, 64'h0,                3'd0, 1'b0);
    vw  = mk(32'hFFF0051B, 64'h0,        3'd0, 1'b1, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
    vl  = mk(32'h12300083, 64'h123,      3'd1, 1'b0, 64'h123,              3'd1, 1'b0);
    vu  = mk(32'h12345037, 64'h12345000, 3'd4, 1'b0, 64'h12345000,         3'd4, 1'b0);
    vjn = mk(32'hFFDFF06F, 64'hFFFFFFFC, 3'd5, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd5, 1'b0);
    vjr = mk(32'h00008067, 64'h0,        3'd1, 1'b0, 64'h0,                3'd1, 1'b0);
    vi1 = mk(32'h0000007F, 64'h0,        3'd0, 1'b1, 64'h0,                3'd0, 1'b1);
    vi2 = mk(32'h00000001, 64'h0,        3'd0, 1'b1, 64'h0,                3'd0, 1'b1);
`ifdef IMM_ZICSR_EN
    vz1 = mk(32'h3002D073, 64'h5,        3'd6, 1'b0, 64'h5,                3'd6, 1'b0);
    vz2 = mk(32'h80002073, 64'h800,      3'd1, 1'b0, 64'h800,              3'd1, 1'b0);
`else
    vz1 = mk(32'h3002D073, 64'h0,        3'd0, 1'b1, 64'h0,                3'd0, 1'b1);
    vz2 = mk(32'h80002073, 64'h0,        3'd0, 1'b1, 64'h0,                3'd0, 1'b1);
`endif

    // Reset state
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_instr  = 32'h0;
    in_tag    = 5'd0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid32", {63'b0, out_valid32}, 64'd0);
    chk("rst_in_ready32",  {63'b0, in_ready32},  64'd0);
    chk("rst_imm32",       {32'b0, out_imm32},   64'd0);
    chk("rst_fmt32",       {61'b0, out_fmt32},   64'd0);
    chk("rst_ill32",       {63'b0, out_illegal32}, 64'd0);
    chk("rst_tag32",       {59'b0, out_tag32},   64'd0);
    chk("rst_out_valid64", {63'b0, out_valid64}, 64'd0);
    chk("rst_in_ready64",  {63'b0, in_ready64},  64'd0);
    chk("rst_imm64",       out_imm64,            64'd0);
    chk("rst_fmt64",       {61'b0, out_fmt64},   64'd0);
    chk("rst_ill64",       {63'b0, out_illegal64}, 64'd0);
    chk("rst_tag64",       {59'b0, out_tag64},   64'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready32_pre", {63'b0, in_ready32}, 64'd0);
    @(negedge clk);
    chk("rel_in_ready32_post", {63'b0, in_ready32}, 64'd1);
    chk("rel_in_ready64_post", {63'b0, in_ready64}, 64'd1);

    // Streaming with out_ready=1: one cycle latency, one result per cycle
    out_ready = 1'b1;
    c0 = cycles;
    send(va, 5'd8);
    chk("lat_out_valid32", {63'b0, out_valid32}, 64'd1);
    chk("lat_imm32", {32'b0, out_imm32}, 64'hFFFFFFFF);
    send(vb, 5'd9);
    send(vc, 5'd10);
    chk("stream_cycles", 64'(cycles - c0), 64'd3);
    send(vd, 5'd11);
    send(ve, 5'd12);
    send(vr, 5'd13);
    send(vw, 5'd14);
    send(vl, 5'd15);
    send(vu, 5'd16);
    send(vjn, 5'd17);
    send(vjr, 5'd18);
    send(vi1, 5'd19);
    send(vi2, 5'd20);
    send(vz1, 5'd21);
    send(vz2, 5'd22);
    idle(3);
    chk("drain1_q32", 64'(q32.size()), 64'd0);
    chk("drain1_q64", 64'(q64.size()), 64'd0);

    // Backpressure: tags 1 and 2 fill output and skid, tag 3 must wait
    out_ready = 1'b0;
    send(va, 5'd1);
    send(vl, 5'd2);
    chk("bp_in_ready32", {63'b0, in_ready32}, 64'd0);
    chk("bp_in_ready64", {63'b0, in_ready64}, 64'd0);
    in_valid = 1'b1;
    in_instr = vu.instr;
    in_tag   = 5'd3;
    for (int i = 0; i < 3; i++) begin
      chk("stall_tag32", {59'b0, out_tag32}, {59'b0, q32[0].tag});
      chk("stall_imm32", {32'b0, out_imm32}, q32[0].imm);
      chk("stall_tag64", {59'b0, out_tag64}, {59'b0, q64[0].tag});
      chk("stall_imm64", out_imm64, q64[0].imm);
      tick(vu, acc);
      chk("stall_no_accept", {63'b0, acc}, 64'd0);
    end
    out_ready = 1'b1;
    send(vu, 5'd3);
    idle(3);
    chk("drain2_q32", 64'(q32.size()), 64'd0);
    chk("drain2_q64", 64'(q64.size()), 64'd0);

    // Reset while in TWO: everything in flight is discarded
    out_ready = 1'b0;
    send(va, 5'd4);
    send(vb, 5'd5);
    in_valid = 1'b0;
    chk("two_in_ready32", {63'b0, in_ready32}, 64'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid32", {63'b0, out_valid32}, 64'd0);
    chk("midrst_out_valid64", {63'b0, out_valid64}, 64'd0);
    chk("midrst_tag32", {59'b0, out_tag32}, 64'd0);
    chk("midrst_in_ready64", {63'b0, in_ready64}, 64'd0);
    #1 rst_n = 1'b1;
    q32.delete();
    q64.delete();
    @(posedge clk);
    @(negedge clk);
    chk("postrst_in_ready32", {63'b0, in_ready32}, 64'd1);
    chk("postrst_in_ready64", {63'b0, in_ready64}, 64'd1);
    chk("postrst_out_valid32", {63'b0, out_valid32}, 64'd0);
    out_ready = 1'b1;
    idle(3);
    vs = vd;
    send(vs, 5'd30);
    send(vw, 5'd31);
    idle(4);
    chk("final_q32", 64'(q32.size()), 64'd0);
    chk("final_q64", 64'(q64.size()), 64'd0);
    chk("final_out_valid64", {63'b0, out_valid64}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 and 64 only.
REQ-002 SHALL have parameter TAG_W, default 5, width of the sideband tag carried alongside each instruction.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  producer has an instruction.
REQ-006 SHALL have port in_ready  output  1  block accepts an instruction this cycle; driven from a register.
REQ-007 SHALL have port in_instr  input  32  raw instruction word.
REQ-008 SHALL have port in_tag  input  TAG_W  opaque sideband, such as ROB index.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result.
REQ-011 SHALL have port out_imm  output  XLEN  decoded immediate.
REQ-012 SHALL have port out_fmt  output  3  format code: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z.
REQ-013 SHALL have port out_illegal  output  1  opcode not recognised.
REQ-014 SHALL have port out_tag  output  TAG_W  tag of the result.

Function
REQ-015 SHALL decode the opcode from in_instr[6:0] as follows:
- 0000011, 0010011, 1100111 decode as I; imm = sign-extended instr[31:20].
- 0100011 decodes as S; imm = sign-extended {instr[31:25], instr[11:7]}.
- 1100011 decodes as B; imm = sign-extended {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- 0110111, 0010111 decode as U; imm = {instr[31:12], 12'b0}.
- 1101111 decodes as J; imm = sign-extended {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
REQ-016 SHALL sign-extend every signed immediate to XLEN; at XLEN=64 U-type SHALL be sign-extended from bit 31.
REQ-017 SHALL treat opcode 0110011 (R-type) as legal with fmt 0 and imm 0.
REQ-018 SHALL treat opcode 0011011 as I-type only when XLEN=64, otherwise as illegal.
REQ-019 SHALL report any other opcode, or instr[1:0] != 2'b11, as out_illegal=1 with fmt 0 and imm 0.
REQ-020 SHALL register results in an output register plus one skid entry, with states EMPTY, ONE (output full) and TWO (output and skid full).
- A transfer occurs on valid && ready.
REQ-021 SHALL assert in_ready exactly when the next state is not TWO; in_ready is registered, never combinational from out_ready.
REQ-022 SHALL have latency of 1 cycle: an accept in EMPTY, or in ONE with a concurrent output transfer, gives out_valid on the next cycle.
REQ-023 SHALL in ONE with an accept and no output transfer, write the result to skid and go to TWO.
REQ-024 SHALL in TWO with an output transfer, move skid to the output and go to ONE; no accept is possible in TWO.
REQ-025 SHALL in ONE with an output transfer and no accept, go to EMPTY.
REQ-026 SHALL hold out_imm, out_fmt, out_illegal and out_tag stable while out_valid && !out_ready.
REQ-027 SHALL preserve order, with no loss or duplication; sustained throughput is 1 per cycle when out_ready=1.
REQ-028 SHALL keep payload registers unchanged on cycles without an accept.

Reset
REQ-029 SHALL, with rst_n low, asynchronously force state EMPTY, out_valid=0, in_ready=0, out_imm=0, out_fmt=0, out_illegal=0 and out_tag=0.
REQ-030 SHALL raise in_ready on the first clock edge after rst_n deasserts.
REQ-031 SHALL discard any in-flight output or skid contents on reset mid-operation; nothing reappears after reset.

Configuration
REQ-032 SHALL have macro IMM_ZICSR_EN; when defined, opcode 1110011 is legal, as follows:
- funct3[2]=1 gives fmt Z, imm = zero-extended instr[19:15].
- funct3 in 1..3 gives fmt I, imm = zero-extended instr[31:20].
- funct3=0 gives fmt 0, imm 0.
- funct3=4 gives illegal.
REQ-033 SHALL, without IMM_ZICSR_EN, report opcode 1110011 as out_illegal=1, fmt 0, imm 0; fmt code 6 is never produced.

Verification
REQ-034 SHALL cover XLEN=32 streaming with out_ready=1: push 0xFFF00093, 0xFE112E23, 0xFE000CE3 -> over 3 consecutive cycles the outputs are (imm 0xFFFFFFFF, fmt 1), (0xFFFFFFFC, fmt 2), (0xFFFFFFF8, fmt 3).
REQ-035 SHALL cover XLEN=64: push 0x800002B7 -> imm 0xFFFFFFFF80000000, fmt 4; push 0x0000006F -> imm 0, fmt 5.
REQ-036 SHALL cover backpressure: with out_ready=0, offer tags 1, 2, 3 -> tags 1 and 2 accepted and in_ready=0 from the cycle after the 2nd accept; with out_ready=1, outputs 1, 2, 3 come in order and outputs are stable while stalled.
REQ-037 SHALL cover an illegal opcode: push 0x0000007F and 0x00000001 -> out_illegal=1, fmt 0, imm 0 for each.
REQ-038 SHALL cover reset mid-operation: in state TWO, pulse rst_n low between edges -> out_valid=0 immediately, in_ready=1 one edge after release, no stale output.
REQ-039 SHALL cover CSR with IMM_ZICSR_EN: push 0x3002D073 (csrrwi, zimm 5) -> imm 5, fmt 6; without the macro the same word gives out_illegal=1.
